// File: rtl/input_pref_ctrl.sv
// -----------------------------------------------------------------------------
// input_pref_ctrl
//   Sequences the input prefetcher that feeds rows into the systolic array (SA).
//   A layer has num_tiles tiles, and each tile has ROWS rows. For every row the
//   block pops the selected source buffer, optionally runs the 16-to-8-bit
//   cutting stage, and then holds the SA load enable until the array accepts
//   the row.
//
//   Ports
//     clk          sole clock; all state changes on its rising edge
//     reset        asynchronous active-high reset
//     start        one-cycle layer start pulse, honoured only in IDLE
//     first_layer  sampled with start: 1 = input buffer, 0 = output buffer
//     num_tiles    tiles in the layer, sampled with start
//     src_valid    selected source holds a row ready to read
//     sa_ready     systolic array accepts the current row this cycle
//     src_rd       one-cycle pop of one row from the selected source
//     en_cutting0  enable for the cutting stage (output-buffer source only)
//     en           prefetcher load enable toward the SA registers
//     buf_select   latched first_layer, inverted
//     bank_sel     ping-pong SA register bank currently being loaded
//     row_idx      row currently being loaded
//     busy         high whenever the FSM is not in IDLE
//     done         one-cycle pulse at the end of a layer
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start
//   FETCH | waiting for src_valid; pops one row when it arrives
//   CUT   | one cycle of requantization (output-buffer source only)
//   LOAD  | en held until sa_ready transfers the row
//   DONE  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module input_pref_ctrl #(
    parameter int N      = 8,
    parameter int ROWS   = 4,
    parameter int TILE_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     first_layer,
    input  logic [TILE_W-1:0]        num_tiles,
    input  logic                     src_valid,
    input  logic                     sa_ready,
    output logic                     src_rd,
    output logic                     en_cutting0,
    output logic                     en,
    output logic                     buf_select,
    output logic                     bank_sel,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int              RW       = $clog2(ROWS);
    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

    // N only describes the lane width of the datapath this block steers.
    if (N < 1 || ROWS < 2 || TILE_W < 1) begin : g_bad_param
        $error("input_pref_ctrl: need N >= 1, ROWS >= 2, TILE_W >= 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CUT   = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [TILE_W-1:0]   num_tiles_q;
    logic [TILE_W-1:0]   tile_cnt;

    logic start_ok;
    logic xfer;
    logic row_last;
    logic tile_last;

    assign start_ok  = (state_q == IDLE) && start && (num_tiles != '0);
    assign xfer      = (state_q == LOAD) && sa_ready;
    assign row_last  = (row_idx == ROW_LAST);
    // num_tiles_q is never zero once a layer is running, so the subtraction
    // cannot underflow; this also lets 2^TILE_W-1 tiles finish without wrap.
    assign tile_last = (tile_cnt == num_tiles_q - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_rd      = 1'b0;
        en_cutting0 = 1'b0;
        en          = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_tiles == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (src_valid) begin
                    src_rd  = 1'b1;
                    state_d = buf_select ? CUT : LOAD;
                end
            end
            CUT: begin
                en_cutting0 = 1'b1;
                state_d     = LOAD;
            end
            LOAD: begin
                en = 1'b1;
                if (sa_ready) begin
                    state_d = (row_last && tile_last) ? DONE : FETCH;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Layer context and row/tile/bank bookkeeping. bank_sel and buf_select
    // deliberately persist through DONE/IDLE until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_select  <= 1'b0;
            bank_sel    <= 1'b0;
            row_idx     <= '0;
            tile_cnt    <= '0;
            num_tiles_q <= '0;
        end else if (start_ok) begin
            buf_select  <= ~first_layer;
            num_tiles_q <= num_tiles;
            bank_sel    <= 1'b0;
            row_idx     <= '0;
            tile_cnt    <= '0;
        end else if (xfer) begin
            if (row_last) begin
                row_idx  <= '0;
                bank_sel <= ~bank_sel;
                tile_cnt <= tile_cnt + 1'b1;
            end else begin
                row_idx  <= row_idx + 1'b1;
            end
        end
    end

endmodule
